// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the memory arbiter slice.
//   arb_state_t : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   ARB_CNT_W   : width of the fetch starvation counter
//   WORD_W      : data/address word width
package mips_pkg;

    localparam int ARB_CNT_W = 4;
    localparam int WORD_W    = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating counter of consecutive data grants made while
// fetch was waiting.
//   clk    in  : clock
//   rst_n  in  : asynchronous active-low reset (counter to 0)
//   inc    in  : count one data grant that bypassed a waiting fetch
//   clr    in  : clear (has priority over inc)
//   at_max out : counter equals FETCH_STARVE_MAX
module arb_starve_ctr
    import mips_pkg::*;
#(
    parameter int FETCH_STARVE_MAX = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [ARB_CNT_W-1:0] CNT_MAX = ARB_CNT_W'(FETCH_STARVE_MAX);

    logic [ARB_CNT_W-1:0] cnt_q;
    logic [ARB_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            // Saturate rather than wrap so a long data burst never
            // makes fetch look un-starved again.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, variable-latency memory between the
// fetch stage (reads) and the memory stage (loads/stores). Data accesses win
// ties unless fetch has been passed over FETCH_STARVE_MAX times in a row.
//   clk, rst_n                         : clock, async active-low reset
//   i_req/i_addr -> i_rdata/i_ack      : fetch port (level request)
//   d_req/d_we/d_addr/d_wdata
//                -> d_rdata/d_ack      : data port (level request)
//   mem_req/mem_we/mem_addr/mem_wdata  : registered memory request
//   mem_ready/mem_rdata                : memory completion and read data
//   stall_f, stall_m                   : pipeline hold for each requester
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int FETCH_STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [WORD_W-1:0] i_addr,
    output logic [WORD_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              stall_f,
    output logic              stall_m
);

    arb_state_t        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;

    logic grant_i;
    logic grant_d;
    logic starve_inc;
    logic starve_clr;
    logic fetch_starved;

    arb_starve_ctr #(
        .FETCH_STARVE_MAX(FETCH_STARVE_MAX)
    ) u_starve_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (fetch_starved)
    );

    // Grant decision and next-state. Requests only ever feed the _d side,
    // so there is no combinational path from i_req/d_req to mem_*.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_i     = 1'b0;
        grant_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req && !(i_req && fetch_starved)) begin
                    grant_d = 1'b1;
                end else if (i_req) begin
                    grant_i = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                // The access completes even if the requester has dropped
                // its request; the result is simply not consumed.
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        if (grant_d) begin
            state_d     = BUSY_D;
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
        end else if (grant_i) begin
            state_d     = BUSY_I;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
        end
    end

    // A data grant only counts against fetch if fetch was actually waiting.
    assign starve_inc = grant_d & i_req;
    assign starve_clr = grant_i | ((state_q == IDLE) & ~i_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Acks are decoded from the registered state, so an asynchronous reset
    // kills them immediately along with mem_req.
    assign i_ack   = (state_q == BUSY_I) & mem_ready;
    assign d_ack   = (state_q == BUSY_D) & mem_ready;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    assign stall_f = i_req & ~i_ack;
    assign stall_m = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
// (FETCH_STARVE_MAX = 2). Memory responses are driven by hand per scenario.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall_f;
    logic        stall_m;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter #(.FETCH_STARVE_MAX(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ack     (i_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .stall_f   (stall_f),
        .stall_m   (stall_m)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant order for the starvation scenario: D D I D D I.
    logic [31:0] starve_exp [6];
    int          wait_tab   [3];
    int          lat_tab    [3];

    initial begin
        rst_n     = 1'b0;
        i_req     = 1'b1;
        i_addr    = 32'h0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = 32'h0;
        d_wdata   = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;

        starve_exp[0] = 32'h1001_0100;
        starve_exp[1] = 32'h1001_0100;
        starve_exp[2] = 32'h0040_0100;
        starve_exp[3] = 32'h1001_0100;
        starve_exp[4] = 32'h1001_0100;
        starve_exp[5] = 32'h0040_0100;
        wait_tab[0] = 0; wait_tab[1] = 1; wait_tab[2] = 5;
        lat_tab[0]  = 1; lat_tab[1]  = 2; lat_tab[2]  = 6;

        // ---------------- reset values ----------------
        tick();
        tick();
        check_eq("rst_mem_req",   {31'b0, mem_req}, 32'd0);
        check_eq("rst_mem_we",    {31'b0, mem_we},  32'd0);
        check_eq("rst_mem_addr",  mem_addr,         32'd0);
        check_eq("rst_mem_wdata", mem_wdata,        32'd0);
        check_eq("rst_acks",      {30'b0, i_ack, d_ack}, 32'd0);
        check_eq("rst_stall_f",   {31'b0, stall_f}, 32'd1);
        i_req = 1'b0;
        #1;
        check_eq("rst_stall_f_low", {31'b0, stall_f}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- fetch only, 0 wait ----------------
        i_req  = 1'b1;
        i_addr = 32'h0040_0000;
        #1;
        check_eq("f_stall_pre", {31'b0, stall_f}, 32'd1);
        tick();
        check_eq("f_mem_req",  {31'b0, mem_req}, 32'd1);
        check_eq("f_mem_addr", mem_addr,         32'h0040_0000);
        check_eq("f_mem_we",   {31'b0, mem_we},  32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'h2008_0005;
        #1;
        check_eq("f_i_ack",   {31'b0, i_ack},   32'd1);
        check_eq("f_d_ack",   {31'b0, d_ack},   32'd0);
        check_eq("f_i_rdata", i_rdata,          32'h2008_0005);
        check_eq("f_stall_f", {31'b0, stall_f}, 32'd0);
        $display("txn fetch addr=0x%08h rdata=0x%08h", mem_addr, i_rdata);
        tick();
        i_req     = 1'b0;
        mem_ready = 1'b0;
        #1;
        check_eq("f_idle_req",  {31'b0, mem_req}, 32'd0);
        check_eq("f_stall_end", {31'b0, stall_f}, 32'd0);
        tick();

        // ---------------- simultaneous: store wins, 3 waits ----------------
        i_req   = 1'b1;
        i_addr  = 32'h0040_0004;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h1001_0000;
        d_wdata = 32'hDEAD_BEEF;
        tick();
        for (int w = 0; w < 3; w++) begin
            check_eq("s_mem_req",   {31'b0, mem_req}, 32'd1);
            check_eq("s_mem_we",    {31'b0, mem_we},  32'd1);
            check_eq("s_mem_addr",  mem_addr,         32'h1001_0000);
            check_eq("s_mem_wdata", mem_wdata,        32'hDEAD_BEEF);
            check_eq("s_no_ack",    {30'b0, i_ack, d_ack}, 32'd0);
            check_eq("s_stalls",    {30'b0, stall_f, stall_m}, 32'd3);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check_eq("s_d_ack", {31'b0, d_ack}, 32'd1);
        check_eq("s_i_ack", {31'b0, i_ack}, 32'd0);
        $display("txn store addr=0x%08h wdata=0x%08h", mem_addr, mem_wdata);
        tick();
        d_req     = 1'b0;
        d_we      = 1'b0;
        mem_ready = 1'b0;
        #1;
        check_eq("s_idle_between", {31'b0, mem_req}, 32'd0);
        tick();
        check_eq("s_f_mem_req",  {31'b0, mem_req}, 32'd1);
        check_eq("s_f_mem_we",   {31'b0, mem_we},  32'd0);
        check_eq("s_f_mem_addr", mem_addr,         32'h0040_0004);
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_1111;
        #1;
        check_eq("s_f_i_ack", {31'b0, i_ack}, 32'd1);
        $display("txn fetch addr=0x%08h rdata=0x%08h", mem_addr, i_rdata);
        tick();
        i_req     = 1'b0;
        mem_ready = 1'b0;
        tick();

        // ---------------- starvation: D D I D D I ----------------
        begin
            int g;
            g = 0;
            i_req  = 1'b1;
            i_addr = 32'h0040_0100;
            d_req  = 1'b1;
            d_we   = 1'b0;
            d_addr = 32'h1001_0100;
            for (int c = 0; c < 12; c++) begin
                if (mem_req) begin
                    if (g < 6) begin
                        check_eq("starve_grant", mem_addr, starve_exp[g]);
                        $display("txn starve grant %0d addr=0x%08h", g, mem_addr);
                    end
                    g++;
                    mem_ready = 1'b1;
                end else begin
                    mem_ready = 1'b0;
                end
                tick();
            end
            i_req     = 1'b0;
            d_req     = 1'b0;
            mem_ready = 1'b0;
            check_eq("starve_count", g, 32'd6);
            tick();
        end

        // ---------------- spurious ready in IDLE ----------------
        mem_ready = 1'b1;
        #1;
        check_eq("sp_acks", {30'b0, i_ack, d_ack}, 32'd0);
        tick();
        check_eq("sp_mem_req", {31'b0, mem_req}, 32'd0);
        check_eq("sp_acks2",   {30'b0, i_ack, d_ack}, 32'd0);
        mem_ready = 1'b0;
        $display("txn spurious ready ignored");
        tick();

        // ---------------- reset mid-transaction ----------------
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h1001_0200;
        tick();   // first wait cycle
        check_eq("r_mem_req_w1", {31'b0, mem_req}, 32'd1);
        tick();   // second wait cycle
        mem_ready = 1'b1;   // ready arrives as reset hits: must not ack
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("r_mem_req_async", {31'b0, mem_req}, 32'd0);
        check_eq("r_d_ack_async",   {31'b0, d_ack},   32'd0);
        check_eq("r_stall_m",       {31'b0, stall_m}, 32'd1);
        mem_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("r_regrant_req",  {31'b0, mem_req}, 32'd1);
        check_eq("r_regrant_addr", mem_addr,         32'h1001_0200);
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        #1;
        check_eq("r_d_ack",   {31'b0, d_ack}, 32'd1);
        check_eq("r_d_rdata", d_rdata,        32'h0BAD_F00D);
        $display("txn load after reset addr=0x%08h rdata=0x%08h", mem_addr, d_rdata);
        tick();
        d_req     = 1'b0;
        mem_ready = 1'b0;
        tick();

        // ---------------- variable latency loads ----------------
        for (int k = 0; k < 3; k++) begin
            int cyc;
            logic acked;
            d_req     = 1'b1;
            d_we      = 1'b0;
            d_addr    = 32'h1001_0300 + 32'(k * 4);
            mem_rdata = 32'hA000_0000 + 32'(k);
            tick();   // grant edge
            cyc   = 1;
            acked = 1'b0;
            while (!acked && cyc <= 20) begin
                mem_ready = (cyc == wait_tab[k] + 1);
                #1;
                if (d_ack) begin
                    acked = 1'b1;
                end else begin
                    check_eq("vl_stall_m", {31'b0, stall_m}, 32'd1);
                    tick();
                    cyc++;
                end
            end
            check_eq("vl_acked",   {31'b0, acked},   32'd1);
            check_eq("vl_latency", cyc,              lat_tab[k]);
            check_eq("vl_d_rdata", d_rdata,          32'hA000_0000 + 32'(k));
            check_eq("vl_stall_m_ack", {31'b0, stall_m}, 32'd0);
            $display("txn load waits=%0d ack_cycle=%0d rdata=0x%08h", wait_tab[k], cyc, d_rdata);
            tick();
            d_req     = 1'b0;
            mem_ready = 1'b0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
